rw_reg: RTL and testbench
=========================

// Module: rw_reg
// PURPOSE
//   Small synchronous 16-bit register file with a single read/write port.
//   - rw selects the operation: write stores a data word at an address; read returns the word at an address.
//   - Used as a scratch/config register bank beside a datapath.
//   - Read data is registered, so downstream logic sees a clean flop output.
// PARAMETERS
//   WIDTH   16  data width of w2, read and every entry
//   DEPTH   16  number of entries
//   ADDR_W  4   address bits taken from w1[ADDR_W-1:0]; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//   clk   in   1      single clock; all state updates on posedge clk
//   rst   in   1      synchronous, active-high reset
//   rw    in   1      1 = write cycle, 0 = read cycle
//   w1    in   WIDTH  address word; low ADDR_W bits index the entry
//   w2    in   WIDTH  write data, used only when rw=1
//   read  out  WIDTH  registered read data
// BEHAVIOUR
//   - Interface: one clock (clk). Reset (rst) is synchronous and active-high.
//   - Reset:
//     - rst=1 at a posedge clears all DEPTH entries and read to 0.
//     - rst has priority over rw.
//     - rw/w1/w2 are don't-care, X-tolerant, while rst=1.
//   - Address range: an address is in range if w1 < DEPTH; every upper bit of w1 above ADDR_W must be 0.
//   - Write (rw=1, in range):
//     - mem[w1] <= w2 at the posedge.
//     - The new value is visible to a read issued in the following cycle.
//   - Write (rw=1, out of range): no entry changes.
//   - read during write cycles: holds its previous value, unless RW_REG_WRITE_THROUGH_EN is defined.
//   - Read (rw=0, in range):
//     - read <= mem[w1] at the posedge.
//     - 1-cycle latency; valid after that edge.
//   - Read (rw=0, out of range): read <= 0.
//   - read holds its value between updates; no combinational path from inputs to read.
//   - No handshake: one operation per cycle, every cycle.
//   - Writing the same address on back-to-back cycles: the last write wins.
//   - Reset asserted mid-sequence: the clear takes effect at that edge; prior writes are lost.
//   - w2 is ignored on read cycles; w1 changes between edges have no effect.
// CONFIGURATION
//   RW_REG_WRITE_THROUGH_EN
//     - Defined: on an in-range write cycle, read <= w2 at the same edge as the store (write-through).
//       On an out-of-range write, read <= 0.
//     - Undefined: read is unchanged on all write cycles.
// TESTING
//   1. rst=1 for 2 cycles -> read=0; then a read of every address 0..15 -> read=0 each.
//   2. rw=1,w1=1,w2=2; next cycle rw=0,w1=1 -> read=2 one cycle after the read edge.
//   3. Write w1=3,w2=16'hBEEF then w1=3,w2=16'h1234; read addr 3 -> 16'h1234.
//      Read addr 4 -> 0.
//   4. rw=1,w1=55,w2=16'hAAAA (out of range); read w1=55 -> 0.
//      Read addr 7 (55 mod 16) -> 0, unchanged.
//   5. Write addr 5 = 16'h00FF, read it, then rw=0 for 3 cycles with w1=5 -> read stays 16'h00FF.
//      Assert rst one cycle -> read=0; re-read addr 5 -> 0.
//   6. Write addr 2 = 16'h5A5A while read holds 16'h00FF:
//      - Without the macro: read stays 16'h00FF during the write.
//      - With RW_REG_WRITE_THROUGH_EN: read=16'h5A5A after that edge.

Source files
------------

// File: rtl/rw_reg.sv
// rw_reg: 16-entry single-port register file with a registered read port.
// Optional feature macro: RW_REG_WRITE_THROUGH_EN (write cycles also update read with w2).
module rw_reg #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rw,
  input  logic [WIDTH-1:0] w1,
  input  logic [WIDTH-1:0] w2,
  output logic [WIDTH-1:0] read
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  read_q;
  logic [WIDTH-1:0]  read_d;
  logic [ADDR_W-1:0] addr_c;
  logic              in_range_c;

  // Full-width compare so any set upper address bit counts as out of range.
  always_comb begin
    addr_c     = w1[ADDR_W-1:0];
    in_range_c = (w1 < WIDTH'(DEPTH));
    read_d     = read_q;
    if (rw) begin
`ifdef RW_REG_WRITE_THROUGH_EN
      read_d = in_range_c ? w2 : '0;
`else
      read_d = read_q;
`endif
    end else begin
      read_d = in_range_c ? mem_q[addr_c] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      read_q <= '0;
    end else begin
      read_q <= read_d;
      if (rw && in_range_c) begin
        mem_q[addr_c] <= w2;
      end
    end
  end

  assign read = read_q;

endmodule

// File: tb/tb_rw_reg.sv
// tb_rw_reg: directed and random checks of rw_reg against an array-based model.
module tb_rw_reg;

  logic        clk;
  logic        rst;
  logic        rw;
  logic [15:0] w1;
  logic [15:0] w2;
  logic [15:0] read;

  int unsigned total;
  int unsigned bad;

  logic [15:0] model_mem [16];
  logic [15:0] model_read;

  rw_reg dut (
    .clk  (clk),
    .rst  (rst),
    .rw   (rw),
    .w1   (w1),
    .w2   (w2),
    .read (read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model follows the behavioural rules, then read is compared.
  task automatic op(input logic r, input logic wr, input logic [15:0] a,
                    input logic [15:0] d, input string tag);
    rst = r;
    rw  = wr;
    w1  = a;
    w2  = d;
    @(posedge clk);
    if (r) begin
      foreach (model_mem[i]) model_mem[i] = 16'h0000;
      model_read = 16'h0000;
    end else if (wr) begin
      if (int'(a) < 16) model_mem[a[3:0]] = d;
`ifdef RW_REG_WRITE_THROUGH_EN
      model_read = (int'(a) < 16) ? d : 16'h0000;
`endif
    end else begin
      model_read = (int'(a) < 16) ? model_mem[a[3:0]] : 16'h0000;
    end
    #1;
    check(tag, read, model_read);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_read = 16'h0000;
    foreach (model_mem[i]) model_mem[i] = 16'h0000;
    rst = 1'b1;
    rw  = 1'b0;
    w1  = '0;
    w2  = '0;

    // Reset with don't-care inputs, then read every entry.
    op(1'b1, 1'bx, 16'hxxxx, 16'hxxxx, "reset0");
    op(1'b1, 1'bx, 16'hxxxx, 16'hxxxx, "reset1");
    check("reset_read", read, 16'h0000);
    for (int i = 0; i < 16; i++) op(1'b0, 1'b0, 16'(i), 16'hFFFF, "reset_scan");

    // Simple write then read.
    op(1'b0, 1'b1, 16'd1, 16'd2, "wr1");
    op(1'b0, 1'b0, 16'd1, 16'h0000, "rd1");
    check("rd1_const", read, 16'h0002);

    // Back-to-back writes to one address: last wins.
    op(1'b0, 1'b1, 16'd3, 16'hBEEF, "wr3a");
    op(1'b0, 1'b1, 16'd3, 16'h1234, "wr3b");
    op(1'b0, 1'b0, 16'd3, 16'h0000, "rd3");
    check("rd3_const", read, 16'h1234);
    op(1'b0, 1'b0, 16'd4, 16'h0000, "rd4");
    check("rd4_const", read, 16'h0000);

    // Out-of-range write must not alias onto addr 7.
    op(1'b0, 1'b1, 16'd55, 16'hAAAA, "wr55");
    op(1'b0, 1'b0, 16'd55, 16'h0000, "rd55");
    check("rd55_const", read, 16'h0000);
    op(1'b0, 1'b0, 16'd7, 16'h0000, "rd7");
    check("rd7_const", read, 16'h0000);

    // Hold behaviour, then mid-sequence reset.
    op(1'b0, 1'b1, 16'd5, 16'h00FF, "wr5");
    for (int i = 0; i < 4; i++) op(1'b0, 1'b0, 16'd5, 16'(i), "rd5_hold");
    check("rd5_const", read, 16'h00FF);
    op(1'b1, 1'b1, 16'd5, 16'h7777, "mid_reset");
    check("mid_reset_const", read, 16'h0000);
    op(1'b0, 1'b0, 16'd5, 16'h0000, "rd5_after_rst");
    check("rd5_after_rst_const", read, 16'h0000);

    // Write while read holds a value.
    op(1'b0, 1'b1, 16'd5, 16'h00FF, "wr5b");
    op(1'b0, 1'b0, 16'd5, 16'h0000, "rd5b");
    op(1'b0, 1'b1, 16'd2, 16'h5A5A, "wr2");
`ifdef RW_REG_WRITE_THROUGH_EN
    check("wr2_through_const", read, 16'h5A5A);
`else
    check("wr2_hold_const", read, 16'h00FF);
`endif
    op(1'b0, 1'b0, 16'd2, 16'h0000, "rd2");
    check("rd2_const", read, 16'h5A5A);

    // Random traffic, including rare resets and out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic        wr;
      logic [15:0] a;
      logic [15:0] d;
      r  = ($urandom_range(0, 39) == 0);
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      d  = 16'($urandom);
      op(r, wr, a, d, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
